wb_rr_arbiter: RTL and testbench
================================

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2: number of Wishbone master ports, legal range 2..8.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width, a multiple of 8; SW = DW/8 is the select width.
REQ-004 SHALL have parameter TIMEOUT, default 255: bus-timeout cycle limit, legal range 1..65535.
REQ-005 SHALL have port wb_clk_i, input, width 1: single clock; all logic is on the rising edge.
REQ-006 SHALL have port wb_rst_i, input, width 1: reset, synchronous and active-high.
REQ-007 SHALL have master-side inputs, each packed master-0-lowest:
- m_adr_i NUM_MASTERS*AW
- m_dat_i NUM_MASTERS*DW
- m_sel_i NUM_MASTERS*SW
- m_we_i, m_cyc_i, m_stb_i NUM_MASTERS each
- m_cti_i NUM_MASTERS*3
- m_bte_i NUM_MASTERS*2
REQ-008 SHALL have master-side outputs:
- m_dat_o NUM_MASTERS*DW
- m_ack_o, m_err_o, m_rty_o NUM_MASTERS each
REQ-009 SHALL have slave-side outputs:
- s_adr_o AW
- s_dat_o DW
- s_sel_o SW
- s_we_o, s_cyc_o, s_stb_o 1 each
- s_cti_o 3
- s_bte_o 2
REQ-010 SHALL have slave-side inputs: s_dat_i DW; s_ack_i, s_err_i, s_rty_i 1 each.
REQ-011 SHALL have status outputs: grant_o NUM_MASTERS, one-hot current owner; timeout_o 1, one-cycle pulse on a bus timeout.

Function
REQ-012 SHALL implement a two-state FSM:
- IDLE -> BUSY when any m_cyc_i is high; the winner is registered as owner.
- BUSY -> IDLE on the cycle the owner's m_cyc_i is sampled low, or on a timeout abort.
REQ-013 SHALL pick the winner by round-robin, searching from (last owner + 1) mod NUM_MASTERS; the last-owner pointer resets to NUM_MASTERS-1 so master 0 wins first after reset.
REQ-014 SHALL register the grant: the first s_cyc_o is 1 cycle after the request is sampled in IDLE.
REQ-015 SHALL hold the grant for the whole owner cycle, including multi-beat bursts (cti 3'b010), whatever the other masters request.
REQ-016 SHALL return to IDLE for 1 cycle after a release, so a new owner gets the bus 2 cycles after the previous owner drops cyc.
REQ-017 SHALL mux the owner's adr/dat/sel/we/cyc/stb/cti/bte to the slave in BUSY, combinationally from the owner register; in IDLE, s_cyc_o and s_stb_o are 0.
REQ-018 SHALL drive s_dat_i onto every m_dat_o lane; ack/err/rty go to the owner only, and non-owners see 0.
REQ-019 SHALL ignore requests from non-owners; they are never acked and are not queued beyond their live m_cyc_i level.
REQ-020 SHALL drive grant_o one-hot to the owner in BUSY and all-zero in IDLE.
REQ-021 SHALL evaluate masters whose cyc rises in the release cycle in the following IDLE cycle.

Reset
REQ-022 SHALL, while wb_rst_i is high, force:
- FSM to IDLE, with no owner
- last-owner pointer to NUM_MASTERS-1
- timeout counter to 0
- grant_o 0, timeout_o 0, s_cyc_o 0, s_stb_o 0
- all m_ack_o, m_err_o, m_rty_o 0
REQ-023 SHALL abandon an in-flight transfer on a reset mid-cycle; no ack or err is delivered for it.

Configuration
REQ-024 SHALL compile the bus timeout only when macro WB_ARB_TIMEOUT_EN is defined.
REQ-025 With WB_ARB_TIMEOUT_EN defined:
- A 16-bit counter increments each BUSY cycle that has s_stb_o high and s_ack_i, s_err_i, s_rty_i all low.
- It clears on any response or on leaving BUSY.
- When it reaches TIMEOUT, the block pulses owner m_err_o and timeout_o for 1 cycle, forces s_cyc_o/s_stb_o low in that same cycle, and goes to IDLE.
REQ-026 Without WB_ARB_TIMEOUT_EN: no counter, timeout_o is tied 0, and a silent slave hangs the owner indefinitely.

Verification
REQ-027 Reset: hold wb_rst_i 3 cycles with all m_cyc_i high -> grant_o=0 and s_cyc_o=0 during reset; master 0 is granted 1 cycle after release.
REQ-028 Round-robin with NUM_MASTERS=3 and all masters holding repeated single reads (each ack 1 cycle after stb) -> grant order 0,1,2,0,1,2, with 1 IDLE cycle between owners.
REQ-029 Burst hold: master 1 does a 4-beat cti=010 write, master 0 requests from beat 2 -> s_cyc_o stays with master 1 through its cti=111 beat; master 0 is granted 2 cycles after master 1 drops cyc.
REQ-030 Response isolation: master 0 owns the bus and the slave acks with s_dat_i=32'hDEADBEEF -> m_ack_o=3'b001, and every m_dat_o lane reads 32'hDEADBEEF.
REQ-031 Timeout, with WB_ARB_TIMEOUT_EN and TIMEOUT=8: the slave never responds -> owner m_err_o and timeout_o pulse on the 8th stalled cycle, s_cyc_o is low in that same cycle, and grant_o=0 on the next cycle.
REQ-032 Same stimulus without WB_ARB_TIMEOUT_EN -> s_cyc_o stays high for 100 cycles and timeout_o stays 0.

Source files
------------

// File: rtl/wb_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter_if
// Bundles the Wishbone signals around the round-robin arbiter: the packed
// master-side buses (master 0 in the lowest slice) and the single slave-side
// bus.
//   modport slave  : the arbiter's view (it is the slave of every master and
//                    drives the downstream slave bus)
//   modport master : the surrounding masters and downstream slave
// ---------------------------------------------------------------------------
interface wb_rr_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32
);
    localparam int SW = DW / 8;

    // master side, into the arbiter
    logic [NUM_MASTERS*AW-1:0] m_adr_i;
    logic [NUM_MASTERS*DW-1:0] m_dat_i;
    logic [NUM_MASTERS*SW-1:0] m_sel_i;
    logic [NUM_MASTERS-1:0]    m_we_i;
    logic [NUM_MASTERS-1:0]    m_cyc_i;
    logic [NUM_MASTERS-1:0]    m_stb_i;
    logic [NUM_MASTERS*3-1:0]  m_cti_i;
    logic [NUM_MASTERS*2-1:0]  m_bte_i;
    // master side, out of the arbiter
    logic [NUM_MASTERS*DW-1:0] m_dat_o;
    logic [NUM_MASTERS-1:0]    m_ack_o;
    logic [NUM_MASTERS-1:0]    m_err_o;
    logic [NUM_MASTERS-1:0]    m_rty_o;
    // slave side, out of the arbiter
    logic [AW-1:0]             s_adr_o;
    logic [DW-1:0]             s_dat_o;
    logic [SW-1:0]             s_sel_o;
    logic                      s_we_o;
    logic                      s_cyc_o;
    logic                      s_stb_o;
    logic [2:0]                s_cti_o;
    logic [1:0]                s_bte_o;
    // slave side, into the arbiter
    logic [DW-1:0]             s_dat_i;
    logic                      s_ack_i;
    logic                      s_err_i;
    logic                      s_rty_i;

    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Round-robin arbiter giving NUM_MASTERS Wishbone masters access to one
// slave. An owner keeps the bus for its whole cyc (bursts included); after a
// release the arbiter spends one IDLE cycle before granting again.
//
// Ports
//   wb_clk_i  : clock, rising edge
//   wb_rst_i  : synchronous active-high reset
//   bus       : wb_rr_arbiter_if.slave, master-side and slave-side buses
//   grant_o   : one-hot current owner, zero while idle
//   timeout_o : one-cycle pulse when a stalled transfer is aborted
//
// Optional feature: define WB_ARB_TIMEOUT_EN to build the bus-timeout
// counter. Without it timeout_o is tied low and a silent slave stalls the
// owner indefinitely.
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    wb_rr_arbiter_if.slave         bus,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   timeout_o
);
    localparam int SW = DW / 8;
    localparam int IW = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || (DW % 8) != 0 ||
        TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("wb_rr_arbiter: illegal parameter value");
    end

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                 state_q;
    logic [IW-1:0]          owner_q;
    logic [IW-1:0]          last_q;
    logic [NUM_MASTERS-1:0] grant_q;

    logic [IW-1:0]          win;
    logic [NUM_MASTERS-1:0] win_oh;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic                   busy;
    logic                   owner_cyc;
    logic                   owner_stb;
    logic                   any_resp;
    logic                   tmo_hit;

    // First requester found when scanning upward from the master after the
    // previous owner, wrapping at NUM_MASTERS.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                              input logic [IW-1:0]          last);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(last) + k) % NUM_MASTERS;
            if (!found && req[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        win              = rr_pick(bus.m_cyc_i, last_q);
        win_oh           = '0;
        win_oh[win]      = 1'b1;
        owner_oh         = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // Reset gates the outputs combinationally so they are quiet from the
    // very first reset cycle, before any state has been loaded.
    assign busy      = (state_q == BUSY) && !wb_rst_i;
    assign owner_cyc = bus.m_cyc_i[owner_q];
    assign owner_stb = bus.m_stb_i[owner_q];
    assign any_resp  = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
            grant_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.m_cyc_i) begin
                        state_q <= BUSY;
                        owner_q <= win;
                        last_q  <= win;
                        grant_q <= win_oh;
                    end
                end
                BUSY: begin
                    if (!owner_cyc || tmo_hit) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Abort on the cycle the count would reach TIMEOUT, so the error lands
    // on the TIMEOUT-th consecutive stalled cycle.
    assign tmo_hit = busy && owner_stb && !any_resp && (tmo_cnt_q == 16'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !busy || !owner_cyc || any_resp || tmo_hit) begin
            tmo_cnt_q <= '0;
        end else if (owner_stb) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign timeout_o = tmo_hit;
    assign grant_o   = wb_rst_i ? '0 : grant_q;

    // Owner's request is passed straight through; cyc/stb are dropped in
    // IDLE and in the abort cycle.
    assign bus.s_adr_o = bus.m_adr_i[int'(owner_q)*AW +: AW];
    assign bus.s_dat_o = bus.m_dat_i[int'(owner_q)*DW +: DW];
    assign bus.s_sel_o = bus.m_sel_i[int'(owner_q)*SW +: SW];
    assign bus.s_cti_o = bus.m_cti_i[int'(owner_q)*3 +: 3];
    assign bus.s_bte_o = bus.m_bte_i[int'(owner_q)*2 +: 2];
    assign bus.s_we_o  = bus.m_we_i[owner_q];
    assign bus.s_cyc_o = busy && owner_cyc && !tmo_hit;
    assign bus.s_stb_o = busy && owner_stb && !tmo_hit;

    assign bus.m_dat_o = {NUM_MASTERS{bus.s_dat_i}};
    assign bus.m_ack_o = busy ? (owner_oh & {NUM_MASTERS{bus.s_ack_i}}) : '0;
    assign bus.m_err_o = busy ? (owner_oh & {NUM_MASTERS{bus.s_err_i | tmo_hit}}) : '0;
    assign bus.m_rty_o = busy ? (owner_oh & {NUM_MASTERS{bus.s_rty_i}}) : '0;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;
    localparam int NM  = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic [NM-1:0] grant_o;
    logic          timeout_o;

    wb_rr_arbiter_if #(.NUM_MASTERS(NM), .AW(AW), .DW(DW)) bus ();

    wb_rr_arbiter #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .bus       (bus),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_no   = 0;

    // master agents
    bit act[NM];
    int beats[NM];
    int gap[NM];
    bit en[NM];
    int nb_cfg[NM];
    bit done_seen[NM];
    bit rand_gap = 1'b0;
    // slave agent: 0 silent, 1 ack the cycle after stb, 2 random response
    int            smode    = 1;
    bit            prev_stb = 1'b0;
    bit            prev_resp = 1'b0;
    bit            rand_dat = 1'b1;
    logic [DW-1:0] fix_dat  = '0;

    // reference model: owner (-1 = bus free), last owner, stalled-cycle run
    int mown   = -1;
    int mlast  = NM - 1;
    int mstall = 0;

    logic [NM-1:0]    obs_grant, obs_mack, obs_merr, prev_grant;
    logic [NM*DW-1:0] obs_mdat;
    logic             obs_scyc, obs_tmo;
    logic [2:0]       obs_cti;
    int               glog[$];
    int               gaplog[$];
    int               zero_run = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bit resp;
        int r;
        for (int i = 0; i < NM; i++) begin
            if (act[i] && done_seen[i]) begin
                beats[i]--;
                if (beats[i] <= 0) begin
                    act[i] = 1'b0;
                    gap[i] = rand_gap ? int'($urandom_range(0, 3)) : 0;
                end
            end else if (!act[i]) begin
                if (gap[i] > 0) gap[i]--;
                else if (en[i]) begin
                    act[i]   = 1'b1;
                    beats[i] = (nb_cfg[i] > 0) ? nb_cfg[i] : int'($urandom_range(1, 4));
                end
            end
            done_seen[i] = 1'b0;
            bus.m_cyc_i[i]           = act[i];
            bus.m_stb_i[i]           = act[i];
            bus.m_we_i[i]            = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.m_cti_i[i*3 +: 3]    = (beats[i] > 1) ? 3'b010 : 3'b111;
            bus.m_bte_i[i*2 +: 2]    = 2'($urandom);
            bus.m_adr_i[i*AW +: AW]  = $urandom;
            bus.m_dat_i[i*DW +: DW]  = $urandom;
            bus.m_sel_i[i*SW +: SW]  = SW'($urandom);
        end
        resp = 1'b0;
        if (smode == 1) resp = prev_stb && !prev_resp;
        if (smode == 2) resp = prev_stb && !prev_resp && ($urandom_range(0, 1) == 1);
        bus.s_ack_i = 1'b0;
        bus.s_err_i = 1'b0;
        bus.s_rty_i = 1'b0;
        if (resp) begin
            r = (smode == 2) ? int'($urandom_range(0, 5)) : 5;
            if (r == 0)      bus.s_err_i = 1'b1;
            else if (r == 1) bus.s_rty_i = 1'b1;
            else             bus.s_ack_i = 1'b1;
        end
        bus.s_dat_i = rand_dat ? DW'($urandom) : fix_dat;
    endtask

    task automatic step();
        int            eown;
        logic [NM-1:0] eg;
        bit            ostb, anyr, hit;
        drive();
        #1;
        eown = wb_rst_i ? -1 : mown;
        eg   = '0;
        if (eown >= 0) eg[eown] = 1'b1;
        ostb = (eown >= 0) ? bus.m_stb_i[eown] : 1'b0;
        anyr = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
`ifdef WB_ARB_TIMEOUT_EN
        hit = ostb && !anyr && (mstall + 1 == TMO);
`else
        hit = 1'b0;
`endif
        chk("grant", grant_o, eg);
        chk("s_cyc", bus.s_cyc_o, (eown >= 0) ? (bus.m_cyc_i[eown] && !hit) : 1'b0);
        chk("s_stb", bus.s_stb_o, ostb && !hit);
        chk("m_ack", bus.m_ack_o, eg & {NM{bus.s_ack_i}});
        chk("m_err", bus.m_err_o, eg & {NM{bus.s_err_i | hit}});
        chk("m_rty", bus.m_rty_o, eg & {NM{bus.s_rty_i}});
        chk("timeout", timeout_o, hit);
        if (eown >= 0) begin
            chk("s_adr", bus.s_adr_o, bus.m_adr_i[eown*AW +: AW]);
            chk("s_dat", bus.s_dat_o, bus.m_dat_i[eown*DW +: DW]);
            chk("s_sel", bus.s_sel_o, bus.m_sel_i[eown*SW +: SW]);
            chk("s_we",  bus.s_we_o,  bus.m_we_i[eown]);
            chk("s_cti", bus.s_cti_o, bus.m_cti_i[eown*3 +: 3]);
            chk("s_bte", bus.s_bte_o, bus.m_bte_i[eown*2 +: 2]);
        end
        for (int i = 0; i < NM; i++) chk("m_dat lane", bus.m_dat_o[i*DW +: DW], bus.s_dat_i);

        obs_grant = grant_o;
        obs_mack  = bus.m_ack_o;
        obs_merr  = bus.m_err_o;
        obs_mdat  = bus.m_dat_o;
        obs_scyc  = bus.s_cyc_o;
        obs_tmo   = timeout_o;
        obs_cti   = bus.s_cti_o;
        for (int i = 0; i < NM; i++) done_seen[i] = bus.m_ack_o[i] | bus.m_err_o[i];
        prev_stb  = bus.s_stb_o;
        prev_resp = anyr;
        if (grant_o != '0 && prev_grant == '0) begin
            for (int j = 0; j < NM; j++) if (grant_o[j]) glog.push_back(j);
            if (glog.size() > 1) gaplog.push_back(zero_run);
            zero_run = 0;
        end else if (grant_o == '0) begin
            zero_run++;
        end
        prev_grant = grant_o;

        // reference model advances on the inputs the DUT samples at this edge
        if (wb_rst_i) begin
            mown = -1; mlast = NM - 1; mstall = 0;
        end else if (mown < 0) begin
            mstall = 0;
            for (int k = 1; k <= NM; k++) begin
                if (bus.m_cyc_i[(mlast + k) % NM]) begin
                    mown = (mlast + k) % NM;
                    break;
                end
            end
            if (mown >= 0) mlast = mown;
        end else if (!bus.m_cyc_i[mown] || hit) begin
            mown = -1; mstall = 0;
        end else if (anyr) begin
            mstall = 0;
        end else if (bus.m_stb_i[mown]) begin
            mstall++;
        end
        cyc_no++;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic do_reset(input int n);
        wb_rst_i = 1'b1;
        for (int i = 0; i < NM; i++) begin
            act[i] = 1'b0; gap[i] = 0; done_seen[i] = 1'b0;
        end
        prev_stb = 1'b0; prev_resp = 1'b0;
        repeat (n) step();
        wb_rst_i = 1'b0;
    endtask

    initial begin
        int t_drop, t_m0, n_ack1, n_last, t_g, t_t, n_hi, n_t;
        bit seen;
        prev_grant = '0;
        for (int i = 0; i < NM; i++) begin
            en[i] = 1'b1; nb_cfg[i] = 1; act[i] = 1'b0; gap[i] = 0; done_seen[i] = 1'b0; beats[i] = 0;
        end

        // reset with every master requesting, then single-read round robin
        smode = 1;
        do_reset(3);
        glog.delete(); gaplog.delete(); zero_run = 0; prev_grant = '0;
        step();
        step();
        chk("grant after reset", obs_grant, 3'b001);
        repeat (30) step();
        chk("rr grants logged", glog.size() >= 6, 1'b1);
        for (int k = 0; k < 6; k++) chk("rr order", (k < glog.size()) ? glog[k] : -1, k % 3);
        for (int k = 0; k < 5; k++) chk("rr idle gap", (k < gaplog.size()) ? gaplog[k] : -1, 1);

        // 4-beat burst from master 1, master 0 joins after the first beat
        for (int i = 0; i < NM; i++) en[i] = 1'b0;
        en[1] = 1'b1; nb_cfg[1] = 4; nb_cfg[0] = 1;
        do_reset(2);
        t_drop = -1; t_m0 = -1; n_ack1 = 0; n_last = 0;
        for (int c = 0; c < 60 && t_m0 < 0; c++) begin
            bit was_act;
            was_act = act[1];
            step();
            if (was_act && !act[1] && t_drop < 0) t_drop = cyc_no - 1;
            if (act[1]) en[1] = 1'b0;
            if (done_seen[1]) en[0] = 1'b1;
            if (obs_grant == 3'b010 && obs_mack[1]) begin
                n_ack1++;
                if (obs_cti == 3'b111) n_last++;
            end
            if (obs_grant == 3'b001 && t_m0 < 0) t_m0 = cyc_no - 1;
        end
        chk("burst beats", n_ack1, 4);
        chk("burst last cti", n_last, 1);
        chk("burst handoff", t_m0 - t_drop, 2);
        nb_cfg[1] = 1;

        // response isolation
        for (int i = 0; i < NM; i++) en[i] = 1'b0;
        en[0] = 1'b1; rand_dat = 1'b0; fix_dat = 32'hDEADBEEF;
        do_reset(2);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            if (obs_mack != '0) begin
                seen = 1'b1;
                chk("iso ack", obs_mack, 3'b001);
                for (int i = 0; i < NM; i++) chk("iso lane", obs_mdat[i*DW +: DW], 32'hDEADBEEF);
            end
        end
        chk("iso ack seen", seen, 1'b1);
        rand_dat = 1'b1;

        // randomized traffic with random responses and occasional resets
        rand_gap = 1'b1; smode = 2;
        for (int i = 0; i < NM; i++) nb_cfg[i] = 0;
        do_reset(2);
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) for (int i = 0; i < NM; i++) en[i] = 1'($urandom_range(0, 1));
            wb_rst_i = ($urandom_range(0, 149) == 0);
            step();
        end
        wb_rst_i = 1'b0;

        // silent slave
        rand_gap = 1'b0; smode = 0;
        for (int i = 0; i < NM; i++) begin en[i] = 1'b0; nb_cfg[i] = 1; end
        en[2] = 1'b1;
        do_reset(2);
`ifdef WB_ARB_TIMEOUT_EN
        t_g = -1; t_t = -1;
        for (int c = 0; c < 40 && t_t < 0; c++) begin
            step();
            if (obs_grant == 3'b100 && t_g < 0) t_g = cyc_no - 1;
            if (obs_tmo) begin
                t_t = cyc_no - 1;
                chk("tmo err", obs_merr, 3'b100);
                chk("tmo s_cyc", obs_scyc, 1'b0);
            end
        end
        chk("tmo seen", t_t >= 0, 1'b1);
        chk("tmo delay", t_t - t_g, TMO - 1);
        step();
        chk("grant after tmo", obs_grant, 3'b000);
`else
        step();
        step();
        n_hi = 0; n_t = 0;
        repeat (100) begin
            step();
            n_hi += int'(obs_scyc);
            n_t  += int'(obs_tmo);
        end
        chk("hang s_cyc", n_hi, 100);
        chk("hang timeout", n_t, 0);
`endif
        // abandon the stalled transfer with a reset
        do_reset(2);
        for (int i = 0; i < NM; i++) en[i] = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
